// File: rtl/count_seq_ctrl.sv
// Sequencer for a 4-bit loadable up/down counter: runs (reps+1) passes from start to end.
// Optional pause input and RUN freeze are compiled in with COUNT_SEQ_PAUSE_EN.
module count_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int REPS_W = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_start,
  input  logic [WIDTH-1:0]  cmd_end,
  input  logic              cmd_dir,
  input  logic [REPS_W-1:0] cmd_reps,
  input  logic              abort,
`ifdef COUNT_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [WIDTH-1:0]  ctr_q,
  output logic              ctr_load,
  output logic              ctr_mode,
  output logic [WIDTH-1:0]  ctr_in,
  output logic              busy,
  output logic              done,
  output logic [REPS_W-1:0] pass_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  start_q, start_d;
  logic [WIDTH-1:0]  end_q, end_d;
  logic              dir_q, dir_d;
  logic [REPS_W-1:0] reps_q, reps_d;
  logic [REPS_W-1:0] pass_q, pass_d;
  logic              frozen;

`ifdef COUNT_SEQ_PAUSE_EN
  assign frozen = pause;
`else
  assign frozen = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    end_d     = end_q;
    dir_d     = dir_q;
    reps_d    = reps_q;
    pass_d    = pass_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    // The counter has no enable, so the idle behaviour is a self-reload.
    ctr_load  = 1'b1;
    ctr_mode  = 1'b0;
    ctr_in    = ctr_q;

    case (state_q)
      S_IDLE: begin
        cmd_ready = !abort;
        if (cmd_valid && !abort) begin
          start_d = cmd_start;
          end_d   = cmd_end;
          dir_d   = cmd_dir;
          reps_d  = cmd_reps;
          pass_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ctr_in  = start_q;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!frozen) begin
          if (ctr_q != end_q) begin
            ctr_load = 1'b0;
            ctr_mode = dir_q;
          end else if (pass_q != reps_q) begin
            ctr_in = start_q;
            pass_d = pass_q + 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a pending completion pulse.
    if (abort) begin
      state_d  = S_IDLE;
      pass_d   = '0;
      done     = 1'b0;
      ctr_load = 1'b1;
      ctr_mode = 1'b0;
      ctr_in   = ctr_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      start_q <= '0;
      end_q   <= '0;
      dir_q   <= 1'b0;
      reps_q  <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      dir_q   <= dir_d;
      reps_q  <= reps_d;
      pass_q  <= pass_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign pass_idx = pass_q;

endmodule
